// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 controller:
// FSM states, instruction classes, ALU op codes, opcode/funct fields.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_PREPARE = 4'd0,
    S_FETCH   = 4'd1,
    S_LATCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB      = 4'd7,
    S_TRAP    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } cls_e;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDI = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd3;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_AND  = 4'd7;
  localparam logic [OP_W-1:0] OP_OR   = 4'd8;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd9;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd10;
  localparam logic [OP_W-1:0] OP_LUI  = 4'd11;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_UIMM = 2'b01;
  localparam logic [1:0] OP2_IIMM = 2'b10;
  localparam logic [1:0] OP2_SIMM = 2'b11;

  localparam logic [1:0] RIN_ALU = 2'b00;
  localparam logic [1:0] RIN_RAM = 2'b01;

  typedef struct packed {
    cls_e            cls;
    logic [OP_W-1:0] op;
    logic [1:0]      op2;
    logic            legal;
  } dec_t;

  // States in which the RAM handshake is live and the wait counter runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instr -> class, ALU op, operand-2
// source and a legality flag. MUL/DIV are legal only when EN_M is set.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec.cls   = CLS_ALU;
    dec.op    = OP_ADD;
    dec.op2   = OP2_RS2;
    dec.legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE,   F3_ADD}: dec.op = OP_ADD;
          {F7_SUB,    F3_ADD}: dec.op = OP_SUB;
          {F7_BASE,   F3_SLL}: dec.op = OP_SLL;
          {F7_BASE,   F3_SRL}: dec.op = OP_SRL;
          {F7_BASE,   F3_XOR}: dec.op = OP_XOR;
          {F7_BASE,   F3_OR }: dec.op = OP_OR;
          {F7_BASE,   F3_AND}: dec.op = OP_AND;
          {F7_MULDIV, F3_ADD}: begin
            dec.op    = OP_MUL;
            dec.legal = EN_M;
          end
          {F7_MULDIV, F3_DIV}: begin
            dec.op    = OP_DIV;
            dec.legal = EN_M;
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.op2   = OP2_IIMM;
        dec.legal = 1'b1;
        case (funct3)
          F3_ADD: dec.op = OP_ADDI;
          F3_XOR: dec.op = OP_XOR;
          F3_OR:  dec.op = OP_OR;
          F3_AND: dec.op = OP_AND;
          // Shift-immediates with a non-zero funct7 (e.g. SRAI) are not supported.
          F3_SLL: begin
            dec.op    = OP_SLL;
            dec.legal = (funct7 == F7_BASE);
          end
          F3_SRL: begin
            dec.op    = OP_SRL;
            dec.legal = (funct7 == F7_BASE);
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op    = OP_LUI;
        dec.op2   = OP2_UIMM;
        dec.legal = 1'b1;
      end
      OPC_LOAD: begin
        dec.cls   = CLS_LOAD;
        dec.op    = OP_ADDI;
        dec.op2   = OP2_IIMM;
        dec.legal = (funct3 == F3_W);
      end
      OPC_STORE: begin
        dec.cls   = CLS_STORE;
        dec.op    = OP_ADDI;
        dec.op2   = OP2_SIMM;
        dec.legal = (funct3 == F3_W);
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle Moore control unit: sequences fetch/decode/execute/memory/
// write-back, with a RAM wait counter, bus timeout and trap pulses.
// RAM handshake: an access is held (ram_cs plus ram_oe or ram_we) from the
// first cycle of FETCH/MEM_RD/MEM_WR until the cycle ram_ready=1, which
// completes it; ram_ready is ignored in every other state.
module ctrl_mc
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 8,
  parameter bit EN_M     = 1'b1,
  parameter int TIMEOUT  = 16,
  parameter int WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                ram_ready,
  output logic                ram_cs,
  output logic                ram_we,
  output logic                ram_oe,
  output logic                pc_en,
  output logic                pc_in_dir,
  output logic                pc_sign,
  output logic                ir_en,
  output logic                reg_en,
  output logic                reg_we,
  output logic [1:0]          reg_in_dir,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          op2_dir,
  output logic                trap_illegal,
  output logic                trap_bus,
  output logic [3:0]          dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  cls_e              cls_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        op2_q;
  logic              trap_ill_q, trap_bus_q;
  dec_t              dec;
  logic              timeout_hit;

  ctrl_decode #(.EN_M(EN_M)) u_decode (
    .instr (instr),
    .dec   (dec)
  );

  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
      assign timeout_hit = !ram_ready && (wait_q == WAIT_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PREPARE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PREPARE: state_d = S_FETCH;
      S_FETCH: begin
        if (ram_ready)        state_d = S_LATCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec.legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (cls_q)
          CLS_LOAD:  state_d = S_MEM_RD;
          CLS_STORE: state_d = S_MEM_WR;
          default:   state_d = S_WB;
        endcase
      end
      S_MEM_RD: begin
        if (ram_ready)        state_d = S_WB;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (ram_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_PREPARE;
    endcase
  end

  // Wait counter restarts on every entry to a RAM state and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (is_wait_state(state_d) && (state_d != state_q)) begin
      wait_q <= '0;
    end else if (is_wait_state(state_q) && !ram_ready && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q <= CLS_ALU;
      op_q  <= '0;
      op2_q <= '0;
    end else if (state_q == S_DECODE) begin
      cls_q <= dec.cls;
      op_q  <= dec.op;
      op2_q <= dec.op2;
    end
  end

  // Trap cause: an entry from DECODE is illegal, from a RAM state is a bus timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_ill_q <= 1'b0;
      trap_bus_q <= 1'b0;
    end else if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
      trap_ill_q <= (state_q == S_DECODE);
      trap_bus_q <= (state_q != S_DECODE);
    end
  end

  always_comb begin
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    pc_en        = 1'b0;
    pc_in_dir    = 1'b0;
    pc_sign      = 1'b0;
    ir_en        = 1'b0;
    reg_en       = 1'b0;
    reg_we       = 1'b0;
    reg_in_dir   = RIN_ALU;
    alu_en       = 1'b0;
    alu_op       = '0;
    op2_dir      = OP2_RS2;
    trap_illegal = 1'b0;
    trap_bus     = 1'b0;
    case (state_q)
      S_FETCH, S_MEM_RD: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
      end
      S_LATCH: begin
        ir_en = 1'b1;
        pc_en = 1'b1;
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        alu_op  = ALU_OP_W'(op_q);
        op2_dir = op2_q;
      end
      S_MEM_WR: begin
        ram_cs = 1'b1;
        ram_we = 1'b1;
      end
      S_WB: begin
        reg_en     = 1'b1;
        reg_we     = 1'b1;
        reg_in_dir = (cls_q == CLS_LOAD) ? RIN_RAM : RIN_ALU;
      end
      S_TRAP: begin
        trap_illegal = trap_ill_q;
        trap_bus     = trap_bus_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ctrl_mc.md
# ctrl_mc

Parametrised multi-cycle control unit for the RV32 core. It sequences fetch, decode, execute, memory and write-back by driving the RAM, PC, IR, register-file and ALU enables. Compared with the first-generation controller it adds:
- asynchronous reset,
- a variable-latency RAM handshake with timeout,
- I-type logic/shift, LUI, LW and SW support,
- an optional M extension,
- trap reporting.

## Interface
Parameters:
- `ALU_OP_W`, 8: width of `alu_op`.
- `EN_M`, 1: 1 = MUL/DIV decoded; 0 = MUL/DIV treated as illegal.
- `TIMEOUT`, 16: maximum wait cycles for `ram_ready`; 0 disables the timeout.
- `WAIT_W`, `$clog2(TIMEOUT+1)`: wait-counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr` in 32: current IR contents.
- `ram_ready` in 1: RAM access complete this cycle.
- `ram_cs`, `ram_we`, `ram_oe` out 1 each: RAM select, write, output enable.
- `pc_en`, `pc_in_dir`, `pc_sign` out 1 each: PC update, source select (0 = +4), sign.
- `ir_en` out 1: IR load.
- `reg_en`, `reg_we` out 1 each: register-file enable, write.
- `reg_in_dir` out 2: write-back source (00 = ALU, 01 = RAM).
- `alu_en` out 1: ALU enable.
- `alu_op` out ALU_OP_W: operation code.
- `op2_dir` out 2: operand-2 source (00 = rs2, 01 = U-imm, 10 = I-imm, 11 = S-imm).
- `trap_illegal`, `trap_bus` out 1 each: one-cycle trap pulses.

## Operation
- Moore FSM. All outputs decode from the state register only. Every output is 0 in any state that does not name it.
- States and what each does:
  - PREPARE: no outputs. Goes to FETCH.
  - FETCH: `ram_cs`, `ram_oe`. Stays until `ram_ready`, then goes to LATCH.
  - LATCH: `ir_en`, `pc_en` (`pc_in_dir`=0, `pc_sign`=0). Goes to DECODE.
  - DECODE: no outputs. Next state comes from `instr`.
  - EXEC: `alu_en`, plus `alu_op`/`op2_dir` held in a register captured at DECODE.
  - MEM_RD: `ram_cs`, `ram_oe`. Stays until `ram_ready`.
  - MEM_WR: `ram_cs`, `ram_we`. Stays until `ram_ready`.
  - WB: `reg_en`, `reg_we`, `reg_in_dir` from the class register.
  - TRAP: the latched trap pulse. Goes to FETCH.
- Decode at DECODE by opcode/funct3/funct7.

  R-type (0110011):

  | Instruction | funct7 | funct3 |
  |---|---|---|
  | ADD | 0000000 | 000 |
  | SUB | 0100000 | 000 |
  | SLL | 0000000 | 001 |
  | SRL | 0000000 | 101 |
  | XOR | 0000000 | 100 |
  | OR | 0000000 | 110 |
  | AND | 0000000 | 111 |
  | MUL (EN_M only) | 0000001 | 000 |
  | DIV (EN_M only) | 0000001 | 100 |

  Other opcodes:
  - I-type 0010011: ADDI, XORI, ORI, ANDI, SLLI, SRLI, with `op2_dir`=10.
  - LUI 0110111: `op2_dir`=01.
  - LW 0000011 funct3 010: OP_ADDI, `op2_dir`=10.
  - SW 0100011 funct3 010: OP_ADDI, `op2_dir`=11.
- Flow per class:
  - ALU and LUI: EXEC → WB (`reg_in_dir`=00) → FETCH.
  - LW: EXEC → MEM_RD → WB (`reg_in_dir`=01) → FETCH.
  - SW: EXEC → MEM_WR → FETCH.
- Any other encoding, including MUL/DIV when EN_M=0, goes DECODE → TRAP with `trap_illegal`=1.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states while `ram_ready`=0.
  - When TIMEOUT≠0, counter == TIMEOUT−1 and `ram_ready`=0, the FSM goes to TRAP with `trap_bus`=1.
  - If `ram_ready` arrives in that same cycle, it wins and there is no trap.
- Trap cause is latched on entry to TRAP. The PC is not advanced for a bus trap in FETCH.

## Timing
- Reset: while `rst_n`=0, the state is PREPARE, the counter and class registers are 0, and all outputs are 0. The first edge after release goes to FETCH.
- Reset asserted mid-instruction aborts it at once, and outputs drop to 0 asynchronously. A RAM write in progress is cut.
- With zero-wait RAM (`ram_ready`=1 on the first cycle):
  - ALU/LUI: 5 cycles, FETCH through WB.
  - LW: 6 cycles.
  - SW: 5 cycles.
- Each wait cycle adds 1.
- `ir_en` and `pc_en` are high for exactly one cycle per instruction. `reg_we` is high for exactly one cycle per ALU/LUI/LW instruction and never for SW or a trap.
- `ram_ready` is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.

## Structure
- Package `ctrl_pkg`:
  - State enum.
  - OP_* codes: ADD 0, ADDI 1, SUB 2, MUL 3, DIV 4, SLL 5, SRL 6, AND 7, OR 8, NOT 9, XOR 10, LUI 11.
  - Opcode/funct constants.
  - `op2_dir` and `reg_in_dir` encodings.
- Sub-module `ctrl_decode`: combinational `instr` → {class, `alu_op`, `op2_dir`, legal}, parametrised by EN_M. The FSM, counter and registers stay in `ctrl_mc`.

## Test plan
- Reset/ADD:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release with `ram_ready`=1 and `instr`=0x002081B3 (add x3,x1,x2).
  - Response: all outputs 0 during reset; `alu_op`=0 and `op2_dir`=00 in EXEC; `reg_we` pulses exactly on cycle 5 after FETCH entry.
- LW with waits:
  - Stimulus: `instr`=0x0040A183; `ram_ready` is low for 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Response: instruction completes in 11 cycles; WB has `reg_in_dir`=01; no trap.
- SW:
  - Stimulus: `instr`=0x0030A223.
  - Response: `op2_dir`=11; `ram_we`=1 for exactly 1 cycle with `ram_ready`=1; `reg_we` never set.
- MUL with EN_M=0:
  - Stimulus: `instr`=0x022081B3.
  - Response: `trap_illegal` pulses 1 cycle after DECODE, then FETCH; no `reg_we`.
- Timeout:
  - Stimulus: TIMEOUT=4, `ram_ready` held 0.
  - Response: `trap_bus` pulses on cycle 5 after FETCH entry and `pc_en` stays 0.
  - Stimulus: repeat with `ram_ready`=1 on the 4th wait cycle.
  - Response: no trap.
- Mid-instruction reset:
  - Stimulus: assert `rst_n`=0 during MEM_WR.
  - Response: `ram_we` drops the same cycle; after release, execution restarts at PREPARE → FETCH.
